// File: rtl/mult_pkg.sv
// mult_pkg: shared types and default widths for the Booth multiplier
// output path (status registers, display register, result FIFO).
package mult_pkg;
  localparam int RES_W = 16;  // signed product width
  localparam int CNT_W = 3;   // Booth iteration counter width

  typedef logic [1:0]              booth_pair_t;
  typedef logic signed [RES_W-1:0] product_t;
endpackage

// File: rtl/mult_result_buffer_if.sv
// mult_result_buffer_if: valid/ready stream carrying completed products
// from the result FIFO head to a consumer (UART / 7-seg scanner).
//   out_valid : head entry present
//   out_data  : head product (0 when out_valid is low)
//   out_ready : consumer accepts the head this cycle
interface mult_result_buffer_if #(
  parameter int RES_W = mult_pkg::RES_W
) ();
  logic                    out_valid;
  logic signed [RES_W-1:0] out_data;
  logic                    out_ready;

  modport master (output out_valid, out_data, input out_ready);
  modport slave  (input out_valid, out_data, output out_ready);
endinterface

// File: rtl/mult_result_fifo.sv
// mult_result_fifo: DEPTH-entry queue of completed products.
//   clk, rst        : clock, async active-high reset
//   clear           : synchronous flush (pointers, level, overflow)
//   push, push_data : enqueue request and product
//   pop             : dequeue request (ignored when empty)
//   out_valid/data  : head entry, data forced to 0 when empty
//   level           : occupancy 0..DEPTH
//   overflow        : sticky, set when a push hits a full queue with no pop
module mult_result_fifo
  import mult_pkg::*;
#(
  parameter int  RES_W = mult_pkg::RES_W,
  parameter int  DEPTH = 4,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    push,
  input  logic signed [RES_W-1:0] push_data,
  input  logic                    pop,
  output logic                    out_valid,
  output logic signed [RES_W-1:0] out_data,
  output logic [LVL_W-1:0]        level,
  output logic                    overflow
);
  localparam int PTR_W = $clog2(DEPTH);

  logic signed [RES_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [LVL_W-1:0]        level_q;
  logic                    full, do_pop, do_push, drop;

  // Level is a separate counter, so pointers can wrap freely and
  // full/empty stay unambiguous.
  assign full    = (level_q == LVL_W'(DEPTH));
  // Pop only from a non-empty queue: a push into empty is never
  // bypassed to the output in the same cycle.
  assign do_pop  = pop && (level_q != '0) && !clear;
  // A full queue still accepts a push when the head leaves this cycle.
  assign do_push = push && !clear && (!full || do_pop);
  assign drop    = push && !clear && full && !do_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: it is only visible through out_valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign level     = level_q;
endmodule

// File: rtl/mult_result_buffer.sv
// mult_result_buffer: output staging for the sequential Booth multiplier.
//   clk, rst          : clock, async active-high reset
//   start, clear      : new-operand pulse (clears display), full flush
//   sig_busy/pair/count/result/done : multiplier status and product
//   busy_q/pair_q/count_q : status registered one cycle
//   disp_result/disp_done : running product, then held final product
//   out_if (master)   : FIFO head stream (out_valid/out_data/out_ready)
//   level, overflow   : FIFO occupancy and sticky drop flag
module mult_result_buffer
  import mult_pkg::*;
#(
  parameter int  RES_W = mult_pkg::RES_W,
  parameter int  CNT_W = mult_pkg::CNT_W,
  parameter int  DEPTH = 4,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    clear,
  input  logic                    sig_busy,
  input  booth_pair_t             sig_pair,
  input  logic [CNT_W-1:0]        sig_count,
  input  logic signed [RES_W-1:0] sig_result,
  input  logic                    sig_done,
  output logic                    busy_q,
  output booth_pair_t             pair_q,
  output logic [CNT_W-1:0]        count_q,
  output logic signed [RES_W-1:0] disp_result,
  output logic                    disp_done,
  mult_result_buffer_if.master    out_if,
  output logic [LVL_W-1:0]        level,
  output logic                    overflow
);
  // Status registers: plain one-cycle delay, untouched by start/clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      pair_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= sig_busy;
      pair_q  <= sig_pair;
      count_q <= sig_count;
    end
  end

  // Display: a new operation blanks it, done latches the final product,
  // busy tracks the running product, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_result <= '0;
      disp_done   <= 1'b0;
    end else if (clear || start) begin
      disp_result <= '0;
      disp_done   <= 1'b0;
    end else if (sig_done) begin
      disp_result <= sig_result;
      disp_done   <= 1'b1;
    end else if (sig_busy) begin
      disp_result <= sig_result;
      disp_done   <= 1'b0;
    end
  end

  logic fifo_valid;

  mult_result_fifo #(
    .RES_W (RES_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (sig_done && !clear),
    .push_data (sig_result),
    .pop       (fifo_valid && out_if.out_ready),
    .out_valid (fifo_valid),
    .out_data  (out_if.out_data),
    .level     (level),
    .overflow  (overflow)
  );

  assign out_if.out_valid = fifo_valid;
endmodule

// File: tb/tb_mult_result_buffer.sv
module tb_mult_result_buffer;
  import mult_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, clear, sig_busy, sig_done;
  booth_pair_t       sig_pair;
  logic [2:0]        sig_count;
  product_t          sig_result;
  logic              busy_q, disp_done, overflow;
  booth_pair_t       pair_q;
  logic [2:0]        count_q;
  product_t          disp_result;
  logic [2:0]        level;

  int total = 0;
  int bad   = 0;

  mult_result_buffer_if #(.RES_W(16)) bus ();

  mult_result_buffer #(.RES_W(16), .CNT_W(3), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .clear       (clear),
    .sig_busy    (sig_busy),
    .sig_pair    (sig_pair),
    .sig_count   (sig_count),
    .sig_result  (sig_result),
    .sig_done    (sig_done),
    .busy_q      (busy_q),
    .pair_q      (pair_q),
    .count_q     (count_q),
    .disp_result (disp_result),
    .disp_done   (disp_done),
    .out_if      (bus),
    .level       (level),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one active edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input int v);
    sig_done = 1'b1; sig_result = product_t'(v);
    step();
    sig_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 0; clear = 0; sig_busy = 0; sig_done = 0;
    sig_pair = '0; sig_count = '0; sig_result = '0; bus.out_ready = 0;
    #12;
    chk("rst_disp", disp_result, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    rst = 1'b0;
    step();

    // 1: display tracks running product, latches final, start blanks it
    sig_busy = 1; sig_pair = 2'b10; sig_count = 3'd1; sig_result = 5;
    step();
    chk("t1_disp5", disp_result, 5);
    chk("t1_done0", disp_done, 0);
    chk("t1_busyq", busy_q, 1);
    chk("t1_pairq", pair_q, 2);
    chk("t1_countq", count_q, 1);
    sig_result = -3; step();
    chk("t1_disp_m3", disp_result, -3);
    sig_result = 12; step();
    chk("t1_disp12", disp_result, 12);
    chk("t1_done0b", disp_done, 0);
    sig_busy = 0; push_one(-42);
    chk("t1_disp_m42", disp_result, -42);
    chk("t1_done1", disp_done, 1);
    chk("t1_busyq0", busy_q, 0);
    step();
    chk("t1_hold", disp_result, -42);
    chk("t1_hold_done", disp_done, 1);
    start = 1; step(); start = 0;
    chk("t1_start_disp", disp_result, 0);
    chk("t1_start_done", disp_done, 0);
    chk("t1_start_keeps_fifo", level, 1);
    chk("t1_head", bus.out_data, -42);
    bus.out_ready = 1; step(); bus.out_ready = 0;
    chk("t1_drained", level, 0);

    // 2: fill, overflow, drain in order
    push_one(7); push_one(-8); push_one(100); push_one(32767);
    chk("t2_level4", level, 4);
    chk("t2_head7", bus.out_data, 7);
    chk("t2_ovf0", overflow, 0);
    push_one(1);
    chk("t2_ovf1", overflow, 1);
    chk("t2_level_full", level, 4);
    bus.out_ready = 1;
    chk("t2_pop7", bus.out_data, 7); step();
    chk("t2_pop_m8", bus.out_data, -8); step();
    chk("t2_pop100", bus.out_data, 100); step();
    chk("t2_pop32767", bus.out_data, 32767); step();
    bus.out_ready = 0;
    chk("t2_empty_valid", bus.out_valid, 0);
    chk("t2_empty_data", bus.out_data, 0);
    chk("t2_ovf_sticky", overflow, 1);
    clear = 1; step(); clear = 0;
    chk("t2_clear_ovf", overflow, 0);

    // 3: push into full while popping is accepted
    push_one(1); push_one(2); push_one(3); push_one(4);
    bus.out_ready = 1; push_one(-1);
    chk("t3_level4", level, 4);
    chk("t3_ovf0", overflow, 0);
    chk("t3_h2", bus.out_data, 2); step();
    chk("t3_h3", bus.out_data, 3); step();
    chk("t3_h4", bus.out_data, 4); step();
    chk("t3_h_m1", bus.out_data, -1); step();
    chk("t3_empty", level, 0);
    bus.out_ready = 0;

    // 4: clear wins over coincident push and pop
    push_one(20); push_one(21);
    chk("t4_level2", level, 2);
    clear = 1; sig_done = 1; sig_result = 55; bus.out_ready = 1;
    step();
    clear = 0; sig_done = 0;
    chk("t4_level0", level, 0);
    chk("t4_valid0", bus.out_valid, 0);
    chk("t4_ovf0", overflow, 0);
    chk("t4_disp0", disp_result, 0);
    step();
    chk("t4_no55", bus.out_valid, 0);
    bus.out_ready = 0;

    // 5: asynchronous reset mid-multiplication
    push_one(30); push_one(31);
    sig_busy = 1; sig_pair = 2'b01; sig_count = 3'd3; sig_result = 9;
    step();
    chk("t5_countq3", count_q, 3);
    chk("t5_level2", level, 2);
    #2 rst = 1'b1;
    #1;
    chk("t5_busyq", busy_q, 0);
    chk("t5_pairq", pair_q, 0);
    chk("t5_countq", count_q, 0);
    chk("t5_disp", disp_result, 0);
    chk("t5_done", disp_done, 0);
    chk("t5_valid", bus.out_valid, 0);
    chk("t5_data", bus.out_data, 0);
    chk("t5_level", level, 0);
    chk("t5_ovf", overflow, 0);
    sig_busy = 0; sig_pair = '0; sig_count = '0; sig_result = '0;
    #2 rst = 1'b0;
    step();

    // 6: pointer wrap with streaming push/pop
    bus.out_ready = 1;
    for (int i = 1; i <= 10; i++) begin
      push_one(i);
      chk("t6_valid", bus.out_valid, 1);
      chk("t6_data", bus.out_data, i);
      chk("t6_level1", level, 1);
    end
    step();
    chk("t6_drained", level, 0);
    chk("t6_ovf0", overflow, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
